// File: rtl/inst_queue.sv
// inst_queue: fetch-to-decode instruction queue for the 5-stage MIPS core.
// A fetch accepted in cycle N is held in a one-entry pending stage. It is
// paired with the SRAM read data in N+1 and written into a DEPTH-entry FIFO.
// Decode drains the FIFO through a valid/ready handshake.
module inst_queue #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    f_valid,
  input  logic [31:0]             f_pc,
  input  logic                    f_adel,
  input  logic                    f_ds,
  input  logic [31:0]             inst_rdata,
  input  logic                    d_ready,
  output logic                    d_valid,
  output logic [31:0]             d_pc,
  output logic [31:0]             d_inst,
  output logic                    d_adel,
  output logic                    d_ds,
  output logic                    stallreq_iq,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW:0] DEPTH_V = (PW + 1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
    logic        ds;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head_entry;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  logic          pend_valid;
  logic [31:0]   pend_pc;
  logic          pend_adel;
  logic          pend_ds;

  logic          fetch_acc;
  logic          pop;
  logic [PW:0]   occupancy;
  logic [31:0]   wr_inst;

  // The extra pointer bit distinguishes full from empty, so the pointer
  // difference is the occupancy directly.
  assign count       = tail - head;
  assign d_valid     = (count != '0);
  // Stall looks only at registered state. It counts the in-flight fetch as
  // occupied and ignores a same-cycle pop, so an accepted fetch always has room.
  assign occupancy   = {1'b0, count} + {{PW{1'b0}}, pend_valid};
  assign stallreq_iq = (occupancy >= DEPTH_V);
  assign fetch_acc   = f_valid & ~stallreq_iq & ~flush;
  assign pop         = d_valid & d_ready;
  // A misaligned fetch never performs a real read, so its SRAM data is replaced by zero.
  assign wr_inst     = pend_adel ? 32'h0 : inst_rdata;

  assign head_entry  = mem[head[AW-1:0]];
  assign d_pc        = head_entry.pc;
  assign d_inst      = head_entry.inst;
  assign d_adel      = head_entry.adel;
  assign d_ds        = head_entry.ds;

  // Pending stage: capture the accepted fetch while its SRAM read is in flight.
  always_ff @(posedge clk) begin
    // NOTE: every sequential update uses <= so that all registers sample pre-edge values together.
    if (rst) begin
      pend_valid <= 1'b0;
      pend_pc    <= '0;
      pend_adel  <= 1'b0;
      pend_ds    <= 1'b0;
    end else begin
      pend_valid <= fetch_acc;
      if (fetch_acc) begin
        pend_pc   <= f_pc;
        pend_adel <= f_adel;
        pend_ds   <= f_ds;
      end
    end
  end

  // Head/tail pointers. Flush empties the queue and discards this cycle's write.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (pend_valid) tail <= tail + 1'b1;
      if (pop)        head <= head + 1'b1;
    end
  end

  // Storage array: write the completed fetch at the tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the array is deliberately cleared on reset so that the d_* outputs read as zero afterwards.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!flush && pend_valid) begin
      mem[tail[AW-1:0]] <= '{pc: pend_pc, inst: wr_inst, adel: pend_adel, ds: pend_ds};
    end
  end

endmodule
